risc16_mc_ctrl: RTL and testbench
=================================

# risc16_mc_ctrl

Multi-cycle control unit for the RiSC-16 single-issue datapath. It sequences one shared ALU, the register file, the PC and a single-port memory through FETCH/DECODE/EXEC/MEM/WB states, and drives the ALU `funct` code and the operand selects per opcode. The memory port is handshaked (`mem_req`/`mem_ready`), so each instruction takes a variable number of cycles.

## Interface
- `ALU_FUNCT_LEN`, from `defines.v`: width of ALU function code; encodings `ALU_ADD`, `ALU_NAND`, `ALU_PASSA`, `ALU_SUB` from `defines.v`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level; permits starting a new instruction.
- `ir_opcode` in 3: IR[15:13].
- `ir_imm7` in 7: IR[6:0]; used only for halt detection.
- `alu_state` in 1: ALU zero flag (combinational from the ALU in the same cycle).
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request, held until `mem_ready`.
- `mem_we` out 1: write qualifier for `mem_req`.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALU result.
- `ir_we` out 1: load IR.
- `pc_we` out 1: load PC.
- `pc_sel` out 2: 0 = PC+1, 1 = PC+1+simm7, 2 = ALU result.
- `rf_we` out 1: register write to rA.
- `rf_wsel` out 2: 0 = ALU result, 1 = memory data, 2 = PC+1.
- `alu_funct` out `ALU_FUNCT_LEN`.
- `alu_asel` out 2: src1 is 0 = regB, 1 = regA, 2 = {imm10,6'b0}.
- `alu_bsel` out 2: src2 is 0 = regC, 1 = simm7, 2 = regB.
- `busy` out 1: state ≠ IDLE and ≠ HALTED.
- `halted` out 1: state = HALTED.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED. The state is registered. All outputs decode combinationally from the state, `ir_opcode`, `mem_ready` and `alu_state`. Outputs not listed for a state are 0.
- IDLE: if `run` is high, go to FETCH.
- FETCH: `mem_req`=1, `mem_addr_sel`=0. On `mem_ready`: `ir_we`=1 and go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle for the register-file read, then go to EXEC.
- EXEC, per opcode:
  - ADD 000: `ALU_ADD`, asel 0, bsel 0; go to WB.
  - ADDI 001: `ALU_ADD`, asel 0, bsel 1; go to WB.
  - NAND 010: `ALU_NAND`, asel 0, bsel 0; go to WB.
  - LUI 011: `ALU_PASSA`, asel 2; go to WB.
  - SW 100 and LW 101: `ALU_ADD`, asel 0, bsel 1; go to MEM.
  - BEQ 110: `ALU_SUB`, asel 1, bsel 2; `pc_we`=1, `pc_sel` = `alu_state` ? 1 : 0; go to FETCH or IDLE.
  - JALR 111: `ALU_PASSA`, asel 0; `pc_we`=1, `pc_sel`=2, `rf_we`=1, `rf_wsel`=2 (PC+1 is computed from the old PC); go to FETCH or IDLE.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we` = (opcode == SW). The ALU controls (`ALU_ADD`, asel 0, bsel 1) are held so the address stays stable.
  - On `mem_ready` for SW: `pc_we`=1, `pc_sel`=0; go to FETCH or IDLE.
  - On `mem_ready` for LW: go to WB.
- WB: `rf_we`=1; `rf_wsel` = 1 for LW, 0 otherwise. ALU controls are held from EXEC. `pc_we`=1, `pc_sel`=0; go to FETCH or IDLE.
- Instruction boundary ("FETCH or IDLE"): go to FETCH if `run`=1, else IDLE. Dropping `run` never aborts an instruction in flight.
- Writes to r0 are filtered by the register file, not by this block.

## Timing
- Reset (async assert): state = IDLE, so every output is 0, including an in-flight `mem_req`. After deassertion, the first FETCH begins on the edge after `run` is sampled high.
- Zero-wait memory (`mem_ready` high in the first request cycle) gives these cycle counts:
  - ADD/ADDI/NAND/LUI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/JALR: 3.
- Each wait cycle on `mem_ready` adds one cycle.
- `mem_req` stays high, with stable `mem_we`/`mem_addr_sel`, from the first request cycle through the `mem_ready` cycle inclusive. It drops in the following cycle unless a new FETCH starts immediately.
- `ir_we` and `pc_we` are single-cycle pulses, and each asserts at most once per instruction.
- `mem_ready` is ignored outside FETCH and MEM.

## Configuration
- `RISC16_HALT_EN` defined:
  - In EXEC, JALR with `ir_imm7` ≠ 0 goes to HALTED with no `pc_we` and no `rf_we`.
  - HALTED: `halted`=1, all other outputs 0. Only `rst` exits this state.
- `RISC16_HALT_EN` undefined:
  - `ir_imm7` is unused, JALR always executes normally, and `halted` is tied to 0.
  - The HALTED state is unreachable.

## Test plan
- Reset, `run`=1, `mem_ready`=1, IR = ADD (0x0000) → IDLE→FETCH→DECODE→EXEC→WB. `alu_funct`=`ALU_ADD` in EXEC. `rf_we`=1 and `pc_we`=1 (`pc_sel` 0) in WB. Next FETCH on cycle 5.
- LW with `mem_ready` held low for 3 MEM cycles → `mem_req`=1, `mem_addr_sel`=1, `mem_we`=0 for 4 cycles. WB follows with `rf_wsel`=1. Total 8 cycles.
- BEQ with `alu_state`=1, then with `alu_state`=0 → EXEC shows `alu_funct`=`ALU_SUB`, asel 1, bsel 2, `pc_we`=1, `pc_sel`=1 and then 0. Next FETCH after 3 cycles.
- JALR, `ir_imm7`=0 → one EXEC cycle with `pc_sel`=2, `rf_we`=1, `rf_wsel`=2, `alu_funct`=`ALU_PASSA`.
- JALR with `ir_imm7`=1 → with `RISC16_HALT_EN`: HALTED, `halted`=1, no `pc_we`/`rf_we`, stays put despite `run`=1. Without it: same response as the JALR scenario above.
- SW in MEM with `mem_ready`=0, assert `rst` mid-cycle → `mem_req`/`mem_we` drop immediately and state = IDLE. `run` low at WB of ADD → returns to IDLE, `busy`=0.

Source files
------------

// File: rtl/risc16_mc_ctrl.sv
// Multi-cycle control unit for the RiSC-16 datapath. It sequences FETCH/DECODE/EXEC/MEM/WB
// over a handshaked memory port. Define RISC16_HALT_EN to make JALR with nonzero imm7 halt.

`ifndef ALU_FUNCT_LEN
`define ALU_FUNCT_LEN 2
`endif
`ifndef ALU_ADD
`define ALU_ADD 2'd0
`endif
`ifndef ALU_NAND
`define ALU_NAND 2'd1
`endif
`ifndef ALU_PASSA
`define ALU_PASSA 2'd2
`endif
`ifndef ALU_SUB
`define ALU_SUB 2'd3
`endif

module risc16_mc_ctrl (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [2:0]                ir_opcode,
  input  logic [6:0]                ir_imm7,
  input  logic                      alu_state,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic                      mem_addr_sel,
  output logic                      ir_we,
  output logic                      pc_we,
  output logic [1:0]                pc_sel,
  output logic                      rf_we,
  output logic [1:0]                rf_wsel,
  output logic [`ALU_FUNCT_LEN-1:0] alu_funct,
  output logic [1:0]                alu_asel,
  output logic [1:0]                alu_bsel,
  output logic                      busy,
  output logic                      halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC1 = 2'd2;

  localparam logic [1:0] ASEL_REGB = 2'd0;
  localparam logic [1:0] ASEL_REGA = 2'd1;
  localparam logic [1:0] ASEL_IMM  = 2'd2;
  localparam logic [1:0] BSEL_REGC = 2'd0;
  localparam logic [1:0] BSEL_IMM  = 2'd1;
  localparam logic [1:0] BSEL_REGB = 2'd2;

  localparam logic [`ALU_FUNCT_LEN-1:0] F_ADD   = `ALU_ADD;
  localparam logic [`ALU_FUNCT_LEN-1:0] F_NAND  = `ALU_NAND;
  localparam logic [`ALU_FUNCT_LEN-1:0] F_PASSA = `ALU_PASSA;
  localparam logic [`ALU_FUNCT_LEN-1:0] F_SUB   = `ALU_SUB;

  state_t state, state_nxt;
  state_t boundary;
  logic   halt_req;

  logic [`ALU_FUNCT_LEN-1:0] dec_funct;
  logic [1:0]                dec_asel;
  logic [1:0]                dec_bsel;

`ifdef RISC16_HALT_EN
  assign halt_req = (ir_imm7 != 7'd0);
  assign halted   = (state == S_HALTED);
`else
  logic unused_imm7;
  assign unused_imm7 = ^ir_imm7;
  assign halt_req    = 1'b0;
  assign halted      = 1'b0;
`endif

  assign busy     = (state != S_IDLE) && (state != S_HALTED);
  assign boundary = run ? S_FETCH : S_IDLE;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ALU setup per opcode; reused unchanged in WB so the result stays stable for the write.
  always_comb begin
    dec_funct = F_ADD;
    dec_asel  = ASEL_REGB;
    dec_bsel  = BSEL_REGC;
    case (ir_opcode)
      OP_ADD:  ;
      OP_ADDI: dec_bsel = BSEL_IMM;
      OP_NAND: dec_funct = F_NAND;
      OP_LUI: begin
        dec_funct = F_PASSA;
        dec_asel  = ASEL_IMM;
      end
      OP_SW, OP_LW: dec_bsel = BSEL_IMM;
      OP_BEQ: begin
        dec_funct = F_SUB;
        dec_asel  = ASEL_REGA;
        dec_bsel  = BSEL_REGB;
      end
      OP_JALR: dec_funct = F_PASSA;
      default: ;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_INC;
    rf_we        = 1'b0;
    rf_wsel      = WSEL_ALU;
    alu_funct    = F_ADD;
    alu_asel     = ASEL_REGB;
    alu_bsel     = BSEL_REGC;

    case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: state_nxt = S_EXEC;

      S_EXEC: begin
        alu_funct = dec_funct;
        alu_asel  = dec_asel;
        alu_bsel  = dec_bsel;
        case (ir_opcode)
          OP_SW, OP_LW: state_nxt = S_MEM;
          OP_BEQ: begin
            pc_we     = 1'b1;
            pc_sel    = alu_state ? PC_BRANCH : PC_INC;
            state_nxt = boundary;
          end
          OP_JALR: begin
            if (halt_req) begin
              state_nxt = S_HALTED;
            end else begin
              // Link value is PC+1 of the current PC, written in the same cycle PC moves.
              pc_we     = 1'b1;
              pc_sel    = PC_ALU;
              rf_we     = 1'b1;
              rf_wsel   = WSEL_PC1;
              state_nxt = boundary;
            end
          end
          default: state_nxt = S_WB;
        endcase
      end

      S_MEM: begin
        alu_funct    = F_ADD;
        alu_asel     = ASEL_REGB;
        alu_bsel     = BSEL_IMM;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (ir_opcode == OP_SW);
        if (mem_ready) begin
          if (ir_opcode == OP_SW) begin
            pc_we     = 1'b1;
            pc_sel    = PC_INC;
            state_nxt = boundary;
          end else begin
            state_nxt = S_WB;
          end
        end
      end

      S_WB: begin
        alu_funct = dec_funct;
        alu_asel  = dec_asel;
        alu_bsel  = dec_bsel;
        rf_we     = 1'b1;
        rf_wsel   = (ir_opcode == OP_LW) ? WSEL_MEM : WSEL_ALU;
        pc_we     = 1'b1;
        pc_sel    = PC_INC;
        state_nxt = boundary;
      end

      S_HALTED: state_nxt = S_HALTED;

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc16_mc_ctrl.sv
// Self-checking bench for risc16_mc_ctrl. Each instruction is expanded into its expected phase
// sequence from the cycle rules, and a negedge compare process checks every output every cycle.

`ifndef ALU_FUNCT_LEN
`define ALU_FUNCT_LEN 2
`endif
`ifndef ALU_ADD
`define ALU_ADD 2'd0
`endif
`ifndef ALU_NAND
`define ALU_NAND 2'd1
`endif
`ifndef ALU_PASSA
`define ALU_PASSA 2'd2
`endif
`ifndef ALU_SUB
`define ALU_SUB 2'd3
`endif

module tb_risc16_mc_ctrl;

  localparam int W = `ALU_FUNCT_LEN;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_HALT} phase_t;

  logic         clk, rst, run, alu_state, mem_ready;
  logic [2:0]   ir_opcode;
  logic [6:0]   ir_imm7;
  logic         mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, busy, halted;
  logic [1:0]   pc_sel, rf_wsel, alu_asel, alu_bsel;
  logic [W-1:0] alu_funct;

  risc16_mc_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode), .ir_imm7(ir_imm7),
    .alu_state(alu_state), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_funct(alu_funct), .alu_asel(alu_asel),
    .alu_bsel(alu_bsel), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Field order: mem_req mem_we mem_addr_sel ir_we pc_we pc_sel rf_we rf_wsel funct asel bsel busy halted
  logic [31:0] dut_vec;
  assign dut_vec = 32'({mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, rf_wsel,
                        alu_funct, alu_asel, alu_bsel, busy, halted});

  function automatic logic halting(input logic [2:0] op, input logic [6:0] imm);
`ifdef RISC16_HALT_EN
    return (op == OP_JALR) && (imm != 7'd0);
`else
    return 1'b0;
`endif
  endfunction

  // ALU setup table: {funct, asel, bsel} for each opcode.
  function automatic logic [W+3:0] alu_tbl(input logic [2:0] op);
    case (op)
      OP_ADD:  return {W'(`ALU_ADD),   2'd0, 2'd0};
      OP_ADDI: return {W'(`ALU_ADD),   2'd0, 2'd1};
      OP_NAND: return {W'(`ALU_NAND),  2'd0, 2'd0};
      OP_LUI:  return {W'(`ALU_PASSA), 2'd2, 2'd0};
      OP_SW:   return {W'(`ALU_ADD),   2'd0, 2'd1};
      OP_LW:   return {W'(`ALU_ADD),   2'd0, 2'd1};
      OP_BEQ:  return {W'(`ALU_SUB),   2'd1, 2'd2};
      default: return {W'(`ALU_PASSA), 2'd0, 2'd0};
    endcase
  endfunction

  function automatic logic [31:0] model(input phase_t p, input logic [2:0] op,
                                        input logic [6:0] imm, input logic rdy, input logic z);
    logic mreq, mwe, masel, irwe, pcwe, rfwe, bsy, hlt;
    logic [1:0] pcs, rfs;
    logic [W+3:0] alu;
    mreq = 0; mwe = 0; masel = 0; irwe = 0; pcwe = 0; rfwe = 0; bsy = 0; hlt = 0;
    pcs = 0; rfs = 0; alu = '0;
    case (p)
      P_FETCH:  begin mreq = 1; irwe = rdy; bsy = 1; end
      P_DECODE: bsy = 1;
      P_EXEC: begin
        bsy = 1;
        alu = alu_tbl(op);
        if (op == OP_BEQ) begin pcwe = 1; pcs = z ? 2'd1 : 2'd0; end
        if (op == OP_JALR && !halting(op, imm)) begin
          pcwe = 1; pcs = 2'd2; rfwe = 1; rfs = 2'd2;
        end
      end
      P_MEM: begin
        bsy = 1; mreq = 1; masel = 1; mwe = (op == OP_SW);
        alu = {W'(`ALU_ADD), 2'd0, 2'd1};
        if (rdy && op == OP_SW) pcwe = 1;
      end
      P_WB: begin
        bsy = 1; alu = alu_tbl(op); rfwe = 1; rfs = (op == OP_LW) ? 2'd1 : 2'd0; pcwe = 1;
      end
      P_HALT: hlt = 1;
      default: ;
    endcase
    return 32'({mreq, mwe, masel, irwe, pcwe, pcs, rfwe, rfs, alu, bsy, hlt});
  endfunction

  logic [31:0] exp_vec;
  logic        exp_valid = 1'b0;

  always @(negedge clk) begin
    if (exp_valid) check("outputs", dut_vec, exp_vec);
  end

  // One cycle: entered at posedge+1, drives inputs, publishes the expectation, ends at next posedge+1.
  task automatic step(input phase_t p, input logic [2:0] op, input logic [6:0] imm,
                      input logic rdy, input logic z, input logic r, output logic pcwe_seen);
    logic [2:0] junk;
    junk      = 3'($urandom_range(7, 0));
    run       = r;
    mem_ready = rdy;
    alu_state = z;
    ir_imm7   = imm;
    ir_opcode = (p == P_FETCH || p == P_IDLE) ? junk : op;
    exp_vec   = model(p, op, imm, rdy, z);
    exp_valid = 1'b1;
    @(negedge clk);
    pcwe_seen = pc_we;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    logic seen;
    for (int i = 0; i < n; i++) step(P_IDLE, OP_ADD, 7'd0, 1'($urandom_range(1, 0)), 1'b0, r, seen);
  endtask

  // Runs one instruction; cyc = cycle index (first FETCH = 1) where the DUT pulsed pc_we, else 0.
  task automatic do_instr(input logic [2:0] op, input logic [6:0] imm, input int fw, input int mw,
                          input logic z, input logic r, output int cyc);
    phase_t q[$];
    logic   rq[$];
    logic   seen;
    int     n;
    for (int i = 0; i <= fw; i++) begin q.push_back(P_FETCH); rq.push_back(i == fw); end
    q.push_back(P_DECODE); rq.push_back(1'b1);
    q.push_back(P_EXEC);   rq.push_back(1'b1);
    if (!halting(op, imm)) begin
      if (op == OP_SW || op == OP_LW)
        for (int i = 0; i <= mw; i++) begin q.push_back(P_MEM); rq.push_back(i == mw); end
      if (op != OP_SW && op != OP_BEQ && op != OP_JALR) begin
        q.push_back(P_WB); rq.push_back(1'b1);
      end
    end
    cyc = 0;
    n   = 0;
    foreach (q[i]) begin
      n++;
      step(q[i], op, imm, rq[i], (q[i] == P_EXEC) ? z : ~z, r, seen);
      if (seen && cyc == 0) cyc = n;
    end
  endtask

  initial begin
    int   cyc;
    logic seen;
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; alu_state = 1'b0;
    ir_opcode = OP_ADD; ir_imm7 = 7'd0;
    #1;
    check("reset_outputs", dut_vec, 32'd0);
    @(posedge clk); #1;
    idle(2, 1'b1);
    rst = 1'b0;
    idle(1, 1'b0);
    check("idle_busy", 32'(busy), 32'd0);
    idle(1, 1'b1);

    do_instr(OP_ADD,  7'd0, 0, 0, 1'b0, 1'b1, cyc); check("add_cycles",  cyc, 4);
    do_instr(OP_ADDI, 7'd5, 0, 0, 1'b1, 1'b1, cyc); check("addi_cycles", cyc, 4);
    do_instr(OP_NAND, 7'd0, 0, 0, 1'b0, 1'b1, cyc); check("nand_cycles", cyc, 4);
    do_instr(OP_LUI,  7'd0, 1, 0, 1'b0, 1'b1, cyc); check("lui_fwait_cycles", cyc, 5);
    do_instr(OP_LW,   7'd2, 0, 3, 1'b0, 1'b1, cyc); check("lw_wait3_cycles", cyc, 8);
    do_instr(OP_LW,   7'd0, 0, 0, 1'b0, 1'b1, cyc); check("lw_cycles",   cyc, 5);
    do_instr(OP_SW,   7'd1, 0, 0, 1'b0, 1'b1, cyc); check("sw_cycles",   cyc, 4);
    do_instr(OP_SW,   7'd1, 2, 1, 1'b1, 1'b1, cyc); check("sw_waits_cycles", cyc, 7);
    do_instr(OP_BEQ,  7'd3, 0, 0, 1'b1, 1'b1, cyc); check("beq_taken_cycles", cyc, 3);
    do_instr(OP_BEQ,  7'd3, 0, 0, 1'b0, 1'b1, cyc); check("beq_nt_cycles", cyc, 3);
    do_instr(OP_JALR, 7'd0, 0, 0, 1'b0, 1'b1, cyc); check("jalr_cycles", cyc, 3);

    // run dropped for the whole ADD: it must still complete, then idle.
    do_instr(OP_ADD,  7'd0, 0, 0, 1'b0, 1'b0, cyc); check("add_norun_cycles", cyc, 4);
    idle(2, 1'b0);
    check("after_norun_busy", 32'(busy), 32'd0);
    idle(1, 1'b1);

    // SW stalled in MEM, reset lands mid-cycle.
    step(P_FETCH,  OP_SW, 7'd0, 1'b1, 1'b0, 1'b1, seen);
    step(P_DECODE, OP_SW, 7'd0, 1'b1, 1'b0, 1'b1, seen);
    step(P_EXEC,   OP_SW, 7'd0, 1'b1, 1'b0, 1'b1, seen);
    step(P_MEM,    OP_SW, 7'd0, 1'b0, 1'b0, 1'b1, seen);
    ir_opcode = OP_SW; mem_ready = 1'b0;
    exp_vec = model(P_MEM, OP_SW, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    exp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we",  32'(mem_we),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1, 1'b1);
    do_instr(OP_ADDI, 7'd9, 0, 0, 1'b0, 1'b1, cyc); check("post_rst_addi_cycles", cyc, 4);

`ifdef RISC16_HALT_EN
    do_instr(OP_JALR, 7'd1, 0, 0, 1'b0, 1'b1, cyc); check("halt_no_pcwe", cyc, 0);
    for (int i = 0; i < 3; i++) step(P_HALT, OP_JALR, 7'd1, 1'b1, 1'b0, 1'b1, seen);
    check("halted_flag", 32'(halted), 32'd1);
    check("halted_busy", 32'(busy), 32'd0);
    exp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("halt_exit_rst", 32'(halted), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1, 1'b0);
`else
    do_instr(OP_JALR, 7'd1, 0, 0, 1'b0, 1'b1, cyc); check("jalr_imm1_cycles", cyc, 3);
    check("jalr_imm1_not_halted", 32'(halted), 32'd0);
`endif

    exp_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
